// File: rtl/aes_uart_sequencer.sv
// aes_uart_sequencer: frames 16 received UART bytes into one AES block, starts
// the core, waits (with timeout) for its result and streams the 16 result bytes
// to the transmit buffer over a valid/ready handshake.
// Optional build macro LF_APPEND_EN: append 0x0D 0x0A after every result block.
module aes_uart_sequencer #(
    parameter int unsigned BLOCK_BYTES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TIMEOUT_W      = 13,
    localparam int unsigned BYTE_W        = 8,
    localparam int unsigned BLK_W         = 128,
    localparam int unsigned CNT_W         = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [BYTE_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              AES_START,
    output logic [BLK_W-1:0]  AES_STATE_IN,
    input  logic [BLK_W-1:0]  AES_STATE_OUT,
    input  logic              AES_DONE,
    output logic              BUSY,
    output logic              RX_OVERRUN,
    output logic              TIMEOUT_ERR
);

    localparam int unsigned REM_W = BLK_W - BYTE_W;
    localparam logic [CNT_W-1:0]     LAST_IDX     = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
`ifdef LF_APPEND_EN
        ST_SEND    = 3'd3,
        ST_CRLF    = 3'd4
`else
        ST_SEND    = 3'd3
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CNT_W-1:0]     r_count,      w_count_nxt;
    logic [TIMEOUT_W-1:0] r_timer,      w_timer_nxt;
    logic [BLK_W-1:0]     r_state_in,   w_state_in_nxt;
    logic [REM_W-1:0]     r_outreg,     w_outreg_nxt;
    logic [BYTE_W-1:0]    r_tx_data,    w_tx_data_nxt;
    logic                 r_tx_valid,   w_tx_valid_nxt;
    logic                 r_aes_start,  w_aes_start_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic                 r_rx_overrun, w_rx_overrun_nxt;
    logic                 r_timeout,    w_timeout_nxt;

    logic                 w_hs;

    assign w_hs = r_tx_valid & TX_READY;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: framing, core handshake, timeout and transmit sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (RX_VALID && (r_count == LAST_IDX)) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // a result arriving on the timeout cycle still wins
                if (AES_DONE)                      w_state_nxt = ST_SEND;
                else if (r_timer == TIMEOUT_LAST)  w_state_nxt = ST_COLLECT;
            end
            ST_SEND: begin
`ifdef LF_APPEND_EN
                if (w_hs && (r_count == LAST_IDX)) w_state_nxt = ST_CRLF;
`else
                if (w_hs && (r_count == LAST_IDX)) w_state_nxt = ST_COLLECT;
`endif
            end
`ifdef LF_APPEND_EN
            ST_CRLF: begin
                if (w_hs && (r_count == CNT_W'(1))) w_state_nxt = ST_COLLECT;
            end
`endif
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // Output/datapath logic: next values for every registered output and data register
    always_comb begin
        w_count_nxt      = r_count;
        w_timer_nxt      = r_timer;
        w_state_in_nxt   = r_state_in;
        w_outreg_nxt     = r_outreg;
        w_tx_data_nxt    = r_tx_data;
        w_timeout_nxt    = 1'b0;
        w_rx_overrun_nxt = RX_VALID && (r_state != ST_COLLECT);
        w_tx_valid_nxt   = (w_state_nxt == ST_SEND);
`ifdef LF_APPEND_EN
        w_tx_valid_nxt   = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_CRLF);
`endif
        w_aes_start_nxt  = (w_state_nxt == ST_START);
        w_busy_nxt       = (w_state_nxt != ST_COLLECT);

        case (r_state)
            ST_COLLECT: begin
                if (RX_VALID) begin
                    w_state_in_nxt = {r_state_in[REM_W-1:0], RX_DATA};
                    w_count_nxt    = r_count + CNT_W'(1);
                end
            end
            ST_START: begin
                w_timer_nxt = '0;
            end
            ST_WAIT: begin
                w_timer_nxt = r_timer + TIMEOUT_W'(1);
                if (AES_DONE) begin
                    w_tx_data_nxt = AES_STATE_OUT[BLK_W-1 -: BYTE_W];
                    w_outreg_nxt  = AES_STATE_OUT[REM_W-1:0];
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_count_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_count_nxt   = r_count + CNT_W'(1);
                    w_tx_data_nxt = r_outreg[REM_W-1 -: BYTE_W];
                    w_outreg_nxt  = {r_outreg[REM_W-BYTE_W-1:0], BYTE_W'(0)};
                    if (r_count == LAST_IDX) begin
`ifdef LF_APPEND_EN
                        w_tx_data_nxt = 8'h0D;
`else
                        w_tx_data_nxt = '0;
`endif
                    end
                end
            end
`ifdef LF_APPEND_EN
            ST_CRLF: begin
                if (w_hs) begin
                    if (r_count == '0) begin
                        w_tx_data_nxt = 8'h0A;
                        w_count_nxt   = CNT_W'(1);
                    end else begin
                        w_tx_data_nxt = '0;
                        w_count_nxt   = '0;
                    end
                end
            end
`endif
            default: begin
                w_count_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count      <= '0;
            r_timer      <= '0;
            r_state_in   <= '0;
            r_outreg     <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_aes_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_timer      <= w_timer_nxt;
            r_state_in   <= w_state_in_nxt;
            r_outreg     <= w_outreg_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_aes_start  <= w_aes_start_nxt;
            r_busy       <= w_busy_nxt;
            r_rx_overrun <= w_rx_overrun_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign TX_DATA      = r_tx_data;
    assign TX_VALID     = r_tx_valid;
    assign AES_START    = r_aes_start;
    assign AES_STATE_IN = r_state_in;
    assign BUSY         = r_busy;
    assign RX_OVERRUN   = r_rx_overrun;
    assign TIMEOUT_ERR  = r_timeout;

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Directed testbench for aes_uart_sequencer (honours LF_APPEND_EN when defined).
module tb_aes_uart_sequencer;

`ifdef LF_APPEND_EN
    localparam int NBYTES = 18;
`else
    localparam int NBYTES = 16;
`endif

    localparam logic [127:0] PT0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT1 = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] CT0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] CT1 = 128'hA5B6C7D8E9FA0B1C2D3E4F5061728394;

    logic         CLK;
    logic         RESET_N;
    logic [7:0]   RX_DATA;
    logic         RX_VALID;
    logic [7:0]   TX_DATA;
    logic         TX_VALID;
    logic         TX_READY;
    logic         AES_START;
    logic [127:0] AES_STATE_IN;
    logic [127:0] AES_STATE_OUT;
    logic         AES_DONE;
    logic         BUSY;
    logic         RX_OVERRUN;
    logic         TIMEOUT_ERR;

    int tests_run    = 0;
    int tests_failed = 0;

    aes_uart_sequencer dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .TX_DATA       (TX_DATA),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY),
        .AES_START     (AES_START),
        .AES_STATE_IN  (AES_STATE_IN),
        .AES_STATE_OUT (AES_STATE_OUT),
        .AES_DONE      (AES_DONE),
        .BUSY          (BUSY),
        .RX_OVERRUN    (RX_OVERRUN),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // expected transmit byte i of a block carrying v (CR/LF trail when appended)
    function automatic logic [7:0] exp_byte(input logic [127:0] v, input int i);
        if (i < 16)       return v[127 - 8*i -: 8];
        else if (i == 16) return 8'h0D;
        else              return 8'h0A;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic send_bytes(input logic [127:0] v, input int first, input int n);
        for (int i = first; i < first + n; i++) send_rx(v[127 - 8*i -: 8]);
    endtask

    task automatic finish_core(input logic [127:0] v);
        AES_STATE_OUT = v;
        AES_DONE      = 1'b1;
        tick();
        AES_DONE      = 1'b0;
        AES_STATE_OUT = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        TX_READY = 1'b1;
        while ((BUSY || TX_VALID) && n < 100) begin
            tick();
            n++;
        end
        TX_READY = 1'b0;
        tests_run++;
        if (BUSY !== 1'b0 || TX_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_idle: busy=%b tx_valid=%b expected 0/0 within 100 cycles", BUSY, TX_VALID);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({TX_DATA, TX_VALID, AES_START, BUSY, RX_OVERRUN, TIMEOUT_ERR} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: data=%h valid=%b start=%b busy=%b ovr=%b tmo=%b expected all 0",
                     TX_DATA, TX_VALID, AES_START, BUSY, RX_OVERRUN, TIMEOUT_ERR);
        end
        tests_run++;
        if (AES_STATE_IN !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_state_in: got %h expected 0", AES_STATE_IN);
        end
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_collect();
        send_bytes(PT0, 0, 15);
        tests_run++;
        if (AES_START !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL collect_15: start=%b busy=%b expected 0/0", AES_START, BUSY);
        end
        tests_run++;
        if (AES_STATE_IN !== 128'h00000102030405060708090A0B0C0D0E) begin
            tests_failed++;
            $display("FAIL collect_partial: got %h expected 00000102030405060708090a0b0c0d0e", AES_STATE_IN);
        end
        send_bytes(PT0, 15, 1);
        tests_run++;
        if (AES_START !== 1'b1 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL collect_start: start=%b busy=%b expected 1/1", AES_START, BUSY);
        end
        tests_run++;
        if (AES_STATE_IN !== PT0) begin
            tests_failed++;
            $display("FAIL collect_state: got %h expected %h", AES_STATE_IN, PT0);
        end
        tick();
        tests_run++;
        if (AES_START !== 1'b0 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_pulse_width: start=%b busy=%b expected 0/1", AES_START, BUSY);
        end
    endtask

    // continues from WAIT cycle 1 left by test_collect; done arrives 10 cycles after START
    task automatic test_return();
        repeat (9) tick();
        tests_run++;
        if (TX_VALID !== 1'b0 || AES_STATE_IN !== PT0) begin
            tests_failed++;
            $display("FAIL wait_quiet: valid=%b state_in=%h expected 0/%h", TX_VALID, AES_STATE_IN, PT0);
        end
        finish_core(CT0);
        TX_READY = 1'b1;
        for (int i = 0; i < NBYTES; i++) begin
            tests_run++;
            if (TX_VALID !== 1'b1 || TX_DATA !== exp_byte(CT0, i)) begin
                tests_failed++;
                $display("FAIL return_byte[%0d]: valid=%b data=%h expected 1/%h", i, TX_VALID, TX_DATA, exp_byte(CT0, i));
            end
            tick();
        end
        TX_READY = 1'b0;
        tests_run++;
        if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL return_end: valid=%b busy=%b expected 0/0", TX_VALID, BUSY);
        end
    endtask

    task automatic test_stall();
        logic [7:0] prev;
        logic       stalled;
        logic       rdy;
        int         idx;
        int         cyc;
        prev = 8'h00; stalled = 1'b0; idx = 0; cyc = 0;
        send_bytes(PT1, 0, 16);
        tick();
        finish_core(CT1);
        while (idx < NBYTES && cyc < 400) begin
            tests_run++;
            if (TX_VALID !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_valid[%0d]: valid=%b expected 1", idx, TX_VALID);
            end
            if (stalled) begin
                tests_run++;
                if (TX_DATA !== prev) begin
                    tests_failed++;
                    $display("FAIL stall_hold[%0d]: data=%h expected %h", idx, TX_DATA, prev);
                end
            end
            rdy      = ($urandom_range(0, 1) != 0);
            TX_READY = rdy;
            if (rdy) begin
                tests_run++;
                if (TX_DATA !== exp_byte(CT1, idx)) begin
                    tests_failed++;
                    $display("FAIL stall_byte[%0d]: data=%h expected %h", idx, TX_DATA, exp_byte(CT1, idx));
                end
                idx++;
            end
            stalled = !rdy;
            prev    = TX_DATA;
            tick();
            cyc++;
        end
        TX_READY = 1'b0;
        tests_run++;
        if (idx != NBYTES) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d bytes expected %0d", idx, NBYTES);
        end
        tests_run++;
        if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_extra: valid=%b busy=%b expected 0/0", TX_VALID, BUSY);
        end
    endtask

    task automatic test_overrun();
        send_bytes(PT0, 0, 16);
        tick();
        tests_run++;
        if (RX_OVERRUN !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_idle: got %b expected 0", RX_OVERRUN);
        end
        send_rx(8'h41);
        tests_run++;
        if (RX_OVERRUN !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got %b expected 1", RX_OVERRUN);
        end
        tick();
        tests_run++;
        if (RX_OVERRUN !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_once: got %b expected 0", RX_OVERRUN);
        end
        finish_core(CT0);
        wait_idle();
        send_bytes(PT1, 0, 16);
        tests_run++;
        if (AES_START !== 1'b1 || AES_STATE_IN !== PT1) begin
            tests_failed++;
            $display("FAIL overrun_next_block: start=%b state_in=%h expected 1/%h", AES_START, AES_STATE_IN, PT1);
        end
        tick();
        finish_core(CT1);
        wait_idle();
    endtask

    task automatic test_timeout();
        int first;
        int pulses;
        int txs;
        first = 0; pulses = 0; txs = 0;
        send_bytes(PT1, 0, 16);
        tests_run++;
        if (AES_START !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_start: got %b expected 1", AES_START);
        end
        for (int i = 1; i <= 4097; i++) begin
            tick();
            if (TIMEOUT_ERR === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (TX_VALID === 1'b1) txs++;
        end
        tests_run++;
        if (first != 4097) begin
            tests_failed++;
            $display("FAIL timeout_cycle: got %0d expected 4097 cycles after START", first);
        end
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_collect: busy=%b expected 0", BUSY);
        end
        tick();
        if (TIMEOUT_ERR === 1'b1) pulses++;
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL timeout_pulses: got %0d expected 1", pulses);
        end
        tests_run++;
        if (txs != 0) begin
            tests_failed++;
            $display("FAIL timeout_no_tx: got %0d valid cycles expected 0", txs);
        end
        send_bytes(PT0, 0, 15);
        tests_run++;
        if (AES_START !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_recount15: start=%b expected 0", AES_START);
        end
        send_bytes(PT0, 15, 1);
        tests_run++;
        if (AES_START !== 1'b1 || AES_STATE_IN !== PT0) begin
            tests_failed++;
            $display("FAIL timeout_recount16: start=%b state_in=%h expected 1/%h", AES_START, AES_STATE_IN, PT0);
        end
        tick();
        finish_core(CT0);
        wait_idle();
    endtask

    task automatic test_reset_mid_send();
        send_bytes(PT0, 0, 16);
        tick();
        finish_core(CT0);
        TX_READY = 1'b1;
        tick();
        tick();
        TX_READY = 1'b0;
        tests_run++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'hE0) begin
            tests_failed++;
            $display("FAIL midsend_before: valid=%b data=%h expected 1/e0", TX_VALID, TX_DATA);
        end
        #2 RESET_N = 1'b0;
        #1;
        tests_run++;
        if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || TX_DATA !== 8'h00) begin
            tests_failed++;
            $display("FAIL midsend_async: valid=%b busy=%b data=%h expected 0/0/00", TX_VALID, BUSY, TX_DATA);
        end
        tick();
        RESET_N = 1'b1;
        tick();
        send_bytes(PT1, 0, 15);
        tests_run++;
        if (AES_START !== 1'b0 || TX_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL midsend_restart15: start=%b valid=%b expected 0/0", AES_START, TX_VALID);
        end
        send_bytes(PT1, 15, 1);
        tests_run++;
        if (AES_START !== 1'b1 || AES_STATE_IN !== PT1) begin
            tests_failed++;
            $display("FAIL midsend_restart16: start=%b state_in=%h expected 1/%h", AES_START, AES_STATE_IN, PT1);
        end
        tick();
        finish_core(CT1);
        wait_idle();
    endtask

    initial begin
        RESET_N       = 1'b0;
        RX_DATA       = 8'h00;
        RX_VALID      = 1'b0;
        TX_READY      = 1'b0;
        AES_STATE_OUT = '0;
        AES_DONE      = 1'b0;
        test_reset();
        test_collect();
        test_return();
        test_stall();
        test_overrun();
        test_timeout();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
